word_triplet_packer: RTL and testbench

Packs a single-word valid/ready stream into three-word triplets and presents each triplet as the `a`, `bb`, `bbbb` operand set for the downstream three-port consumer stage (the 32-bit `a`/`bb`/`bbbb` module). It sits directly upstream of that consumer. Partial groups are closed early by `i_last`, and completed triplets are buffered in a small output FIFO so upstream traffic continues while the consumer stalls.

---
 rtl/word_triplet_packer_pkg.sv | 20 ++
 rtl/word_triplet_packer_fifo.sv | 52 +++++
 rtl/word_triplet_packer.sv | 111 +++++++++++
 tb/tb_word_triplet_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/word_triplet_packer_pkg.sv
// Shared types for the word triplet packer: fill states and the buffered triplet record.
package word_triplet_packer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FILL_A    = 2'd0,
    FILL_BB   = 2'd1,
    FILL_BBBB = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] bb;
    logic [WORD_W-1:0] bbbb;
    logic [1:0]        count;
    logic              last;
  } triplet_t;

endpackage

// File: rtl/word_triplet_packer_fifo.sv
// Circular triplet FIFO; storage is cleared on reset so an empty FIFO reads all-zero fields.
module triplet_fifo
  import word_triplet_packer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  triplet_t                 push_data,
  input  logic                     pop,
  output triplet_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  triplet_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_triplet_packer.sv
// Packs a single-word stream into a/bb/bbbb triplets, closing early on i_last.
//   state     | meaning
//   FILL_A    | no word held; next word lands in slot a
//   FILL_BB   | a held; next word lands in slot bb
//   FILL_BBBB | a and bb held; next word completes the triplet
module word_triplet_packer
  import word_triplet_packer_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [WIDTH-1:0]          o_a,
  output logic [WIDTH-1:0]          o_bb,
  output logic [WIDTH-1:0]          o_bbbb,
  output logic [1:0]                o_count,
  output logic                      o_last,
  output logic [$clog2(DEPTH):0]    o_level
);

  fill_state_e       state;
  logic [WIDTH-1:0]  hold_a;
  logic [WIDTH-1:0]  hold_bb;

  triplet_t          wr_trip;
  triplet_t          head;
  logic              full;
  logic              empty;
  logic              closing;
  logic              accept;
  logic              push;
  logic              pop;

  // A word closes the triplet in the last slot or when it ends a packet.
  assign closing = (state == FILL_BBBB) || i_last;
  assign i_ready = closing ? (!full || o_ready) : 1'b1;
  assign accept  = i_valid && i_ready;
  assign push    = accept && closing;
  assign pop     = !empty && o_ready;

  always_comb begin
    wr_trip      = '0;
    wr_trip.last = i_last;
    unique case (state)
      FILL_A: begin
        wr_trip.a     = WORD_W'(i_data);
        wr_trip.count = 2'd1;
      end
      FILL_BB: begin
        wr_trip.a     = WORD_W'(hold_a);
        wr_trip.bb    = WORD_W'(i_data);
        wr_trip.count = 2'd2;
      end
      default: begin
        wr_trip.a     = WORD_W'(hold_a);
        wr_trip.bb    = WORD_W'(hold_bb);
        wr_trip.bbbb  = WORD_W'(i_data);
        wr_trip.count = 2'd3;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= FILL_A;
      hold_a  <= '0;
      hold_bb <= '0;
    end else if (accept) begin
      if (closing) begin
        state   <= FILL_A;
        hold_a  <= '0;
        hold_bb <= '0;
      end else if (state == FILL_A) begin
        hold_a <= i_data;
        state  <= FILL_BB;
      end else begin
        hold_bb <= i_data;
        state   <= FILL_BBBB;
      end
    end
  end

  triplet_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (wr_trip),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  assign o_valid = !empty;
  assign o_a     = head.a[WIDTH-1:0];
  assign o_bb    = head.bb[WIDTH-1:0];
  assign o_bbbb  = head.bbbb[WIDTH-1:0];
  assign o_count = head.count;
  assign o_last  = head.last;

endmodule

// File: tb/tb_word_triplet_packer.sv
// Directed vector table, hand sequences for backpressure/reset, and a random scoreboard run.
module tb_word_triplet_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_a, o_bb, o_bbbb;
  logic [1:0]  o_count;
  logic        o_last;
  logic [1:0]  o_level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  word_triplet_packer #(.WIDTH(32), .DEPTH(2)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_a     (o_a),
    .o_bb    (o_bb),
    .o_bbbb  (o_bbbb),
    .o_count (o_count),
    .o_last  (o_last),
    .o_level (o_level)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic        chk_data;
    logic [31:0] ea, ebb, ebbbb;
    logic [1:0]  ecnt;
    logic        elast;
    logic [1:0]  elvl;
  } vec_t;

  typedef struct {
    logic [31:0] a, bb, bbbb;
    logic [1:0]  cnt;
    logic        last;
  } trip_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    forever begin
      @(negedge clk);
      if (i_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  vec_t  vecs [15];
  trip_t q [$];
  trip_t cur, t;
  int    fidx;
  logic  closing_m, exp_rdy;
  int    guard;

  initial begin
    vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 32'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, 32'h13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 32'h14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 32'h12, 32'h13, 2'd3, 1'b0, 2'd1};
    vecs[5]  = '{1'b1, 32'h15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 32'h16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h15, 32'h16, 2'd3, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[10] = '{1'b1, 32'hB,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA,  32'hB,  32'h0,  2'd2, 1'b1, 2'd1};
    vecs[12] = '{1'b1, 32'h5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5,  32'h0,  32'h0,  2'd1, 1'b1, 2'd1};
    vecs[14] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  2'd0, 1'b0, 2'd0};

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: one row per cycle, outputs sampled mid-cycle.
    for (int i = 0; i < 15; i++) begin
      i_valid = vecs[i].v; i_data = vecs[i].d; i_last = vecs[i].l; o_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_i_ready", i), 64'(i_ready), 64'(vecs[i].e_irdy));
      chk($sformatf("vec%0d_o_valid", i), 64'(o_valid), 64'(vecs[i].e_ovld));
      chk($sformatf("vec%0d_o_level", i), 64'(o_level), 64'(vecs[i].elvl));
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d_o_a", i),     64'(o_a),     64'(vecs[i].ea));
        chk($sformatf("vec%0d_o_bb", i),    64'(o_bb),    64'(vecs[i].ebb));
        chk($sformatf("vec%0d_o_bbbb", i),  64'(o_bbbb),  64'(vecs[i].ebbbb));
        chk($sformatf("vec%0d_o_count", i), 64'(o_count), 64'(vecs[i].ecnt));
        chk($sformatf("vec%0d_o_last", i),  64'(o_last),  64'(vecs[i].elast));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;

    // Backpressure: fill both FIFO entries, hold two words, stall the ninth.
    o_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_word(32'h31 + k, 1'b0);
    i_valid = 1'b1; i_data = 32'h39; i_last = 1'b0;
    @(negedge clk);
    chk("bp_i_ready_full", 64'(i_ready), 64'd0);
    chk("bp_level_full", 64'(o_level), 64'd2);
    chk("bp_head_a", 64'(o_a), 64'h31);
    chk("bp_head_bbbb", 64'(o_bbbb), 64'h33);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_i_ready_hold", 64'(i_ready), 64'd0);
    @(posedge clk); #1;
    o_ready = 1'b1;
    @(negedge clk);
    chk("bp_i_ready_pop", 64'(i_ready), 64'd1);
    @(posedge clk); #1;
    o_ready = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("bp_level_after", 64'(o_level), 64'd2);
    chk("bp_head2_a", 64'(o_a), 64'h34);
    chk("bp_head2_bbbb", 64'(o_bbbb), 64'h36);
    o_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_head3_a", 64'(o_a), 64'h37);
    chk("bp_head3_bb", 64'(o_bb), 64'h38);
    chk("bp_head3_bbbb", 64'(o_bbbb), 64'h39);
    chk("bp_head3_count", 64'(o_count), 64'd3);
    chk("bp_level_one", 64'(o_level), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained_valid", 64'(o_valid), 64'd0);
    chk("bp_drained_level", 64'(o_level), 64'd0);
    @(posedge clk); #1;

    // Reset with two words held must discard them.
    send_word(32'h41, 1'b0);
    send_word(32'h42, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_o_a", 64'(o_a), 64'd0);
    @(posedge clk); #1;
    send_word(32'h21, 1'b0);
    send_word(32'h22, 1'b0);
    send_word(32'h23, 1'b0);
    @(negedge clk);
    chk("rst_trip_valid", 64'(o_valid), 64'd1);
    chk("rst_trip_a", 64'(o_a), 64'h21);
    chk("rst_trip_bb", 64'(o_bb), 64'h22);
    chk("rst_trip_bbbb", 64'(o_bbbb), 64'h23);
    chk("rst_trip_count", 64'(o_count), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_only_one", 64'(o_valid), 64'd0);
    @(posedge clk); #1;

    // Random traffic against a reference packing model.
    fidx = 0;
    cur  = '{32'h0, 32'h0, 32'h0, 2'd0, 1'b0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = $urandom;
      i_last  = ($urandom_range(0, 4) == 0);
      o_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      closing_m = (fidx == 2) || i_last;
      exp_rdy   = closing_m ? ((q.size() < 2) || o_ready) : 1'b1;
      chk("rnd_i_ready", 64'(i_ready), 64'(exp_rdy));
      chk("rnd_o_valid", 64'(o_valid), 64'(q.size() != 0));
      chk("rnd_o_level", 64'(o_level), 64'(q.size()));
      if (o_valid && o_ready && q.size() > 0) begin
        t = q.pop_front();
        chk("rnd_a", 64'(o_a), 64'(t.a));
        chk("rnd_bb", 64'(o_bb), 64'(t.bb));
        chk("rnd_bbbb", 64'(o_bbbb), 64'(t.bbbb));
        chk("rnd_count", 64'(o_count), 64'(t.cnt));
        chk("rnd_last", 64'(o_last), 64'(t.last));
      end
      if (i_valid && i_ready) begin
        if (fidx == 0) cur.a = i_data;
        else if (fidx == 1) cur.bb = i_data;
        else cur.bbbb = i_data;
        if (closing_m) begin
          cur.cnt  = 2'(fidx + 1);
          cur.last = i_last;
          q.push_back(cur);
          cur  = '{32'h0, 32'h0, 32'h0, 2'd0, 1'b0};
          fidx = 0;
        end else begin
          fidx++;
        end
      end
      @(posedge clk); #1;
    end

    i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      chk("drain_o_valid", 64'(o_valid), 64'd1);
      t = q.pop_front();
      chk("drain_a", 64'(o_a), 64'(t.a));
      chk("drain_bbbb", 64'(o_bbbb), 64'(t.bbbb));
      chk("drain_count", 64'(o_count), 64'(t.cnt));
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    chk("drain_level", 64'(o_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
